// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 datapath constants and stage-1 register type
//
// Purpose : widths, exponent bias and the normalise stage-1 record used by
//           the FP32 datapath blocks.
// Contents: MANT_W, EXP_W, LZC_W, BIAS, norm_s1_t.
package fpu_pkg;

  localparam int MANT_W = 32;
  localparam int EXP_W  = 10;
  localparam int LZC_W  = $clog2(MANT_W) + 1;
  localparam int BIAS   = 127;

  // Stage-1 record of the normalise stage: the raw operand plus its
  // leading-zero count and a zero flag, so stage 2 never re-scans the mantissa.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic [LZC_W-1:0]  lzc;
    logic              zero;
  } norm_s1_t;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter
//
// Purpose : count leading zeros of a 32-bit word; an all-zero word gives 32.
// Ports   : d   (in, 32) word to scan
//           cnt (out, 6) leading-zero count, 0..32
module lzc32
  import fpu_pkg::*;
(
  input  logic [31:0]      d,
  output logic [LZC_W-1:0] cnt
);

  // Each tree node holds a "has a one" flag and the zero count inside its
  // span. Counts are carried at 5 bits on every level to keep widths uniform;
  // only the low log2(span) bits are ever non-zero.
  logic [15:0] v1;
  logic [7:0]  v2;
  logic [3:0]  v3;
  logic [1:0]  v4;
  logic        v5;
  logic [4:0]  c1 [16];
  logic [4:0]  c2 [8];
  logic [4:0]  c3 [4];
  logic [4:0]  c4 [2];
  logic [4:0]  c5;

  always_comb begin
    // 2-bit encoders: the count is 1 only when the upper bit is clear.
    for (int i = 0; i < 16; i++) begin
      v1[i] = d[2*i+1] | d[2*i];
      c1[i] = {4'b0000, ~d[2*i+1]};
    end
    // Merge: if the upper half holds a one, its count stands; otherwise the
    // whole upper half is zeros, so add its span (a single set bit, since the
    // lower count is always smaller than the span).
    for (int i = 0; i < 8; i++) begin
      v2[i] = v1[2*i+1] | v1[2*i];
      c2[i] = v1[2*i+1] ? c1[2*i+1] : (c1[2*i] | 5'd2);
    end
    for (int i = 0; i < 4; i++) begin
      v3[i] = v2[2*i+1] | v2[2*i];
      c3[i] = v2[2*i+1] ? c2[2*i+1] : (c2[2*i] | 5'd4);
    end
    for (int i = 0; i < 2; i++) begin
      v4[i] = v3[2*i+1] | v3[2*i];
      c4[i] = v3[2*i+1] ? c3[2*i+1] : (c3[2*i] | 5'd8);
    end
    v5 = v4[1] | v4[0];
    c5 = v4[1] ? c4[1] : (c4[0] | 5'd16);
    cnt = v5 ? {1'b0, c5} : 6'd32;
  end

endmodule

// File: rtl/fp32_norm_stage.sv
// rtl/fp32_norm_stage.sv - pipelined leading-zero count and normalise stage
//
// Purpose : shift the mantissa so its leading one sits at bit 31, adjust the
//           exponent, clamp to subnormal on underflow. Two register stages,
//           valid/ready on both sides, full throughput.
// Ports   : clk, rst_n (sync, active low)
//           in_valid/in_ready, in_sign, in_exp (signed biased), in_mant
//           out_valid/out_ready, out_sign, out_exp, out_mant, out_lzc,
//           out_zero, out_denorm
module fp32_norm_stage #(
  parameter  int MANT_W = 32,
  parameter  int EXP_W  = 10,
  localparam int LZC_W  = $clog2(MANT_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic [LZC_W-1:0]  out_lzc,
  output logic              out_zero,
  output logic              out_denorm
);

  fpu_pkg::norm_s1_t s1_q;
  logic              s1_valid;
  logic              s2_valid;
  logic              adv1;
  logic              adv2;
  logic [LZC_W-1:0]  in_lzc;

  // Stage-2 next values.
  logic [EXP_W-1:0]  exp_adj;
  logic [EXP_W-1:0]  uf_shift;
  logic [EXP_W-1:0]  n_exp;
  logic [MANT_W-1:0] n_mant;
  logic              n_denorm;

  // A stage may load whenever its own content is leaving or it is empty;
  // the ready path is combinational from out_ready so a full pipe still
  // streams one item per cycle.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  lzc32 u_lzc (
    .d   (in_mant),
    .cnt (in_lzc)
  );

  // Stage 1: capture operand, count and zero flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.sign <= in_sign;
        s1_q.exp  <= in_exp;
        s1_q.mant <= in_mant;
        s1_q.lzc  <= in_lzc;
        s1_q.zero <= (in_mant == '0);
      end
    end
  end

  // Stage 2 datapath. The exponent is signed; lzc is zero-extended before
  // the subtract so a count of 32 stays positive.
  always_comb begin
    exp_adj  = s1_q.exp - {{(EXP_W-LZC_W){1'b0}}, s1_q.lzc};
    // On underflow only shift as far as the exponent can pay for, landing at
    // exponent 1 minus one (the subnormal encoding 0). A non-positive
    // exponent gets no shift at all.
    uf_shift = ($signed(s1_q.exp) > 1) ? (s1_q.exp - 1'b1) : '0;
    n_exp    = '0;
    n_mant   = '0;
    n_denorm = 1'b0;
    if (s1_q.zero) begin
      n_exp    = '0;
      n_mant   = '0;
      n_denorm = 1'b0;
    end else if ($signed(exp_adj) >= 1) begin
      n_exp    = exp_adj;
      n_mant   = s1_q.mant << s1_q.lzc;
      n_denorm = 1'b0;
    end else begin
      n_exp    = '0;
      n_mant   = s1_q.mant << uf_shift;
      n_denorm = 1'b1;
    end
  end

  // Stage 2 / output register. Data only changes when a real item moves in,
  // so held outputs are bit-stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_mant   <= '0;
      out_lzc    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign   <= s1_q.sign;
        out_exp    <= n_exp;
        out_mant   <= n_mant;
        out_lzc    <= s1_q.lzc;
        out_zero   <= s1_q.zero;
        out_denorm <= n_denorm;
      end
    end
  end

endmodule

// File: tb/tb_fp32_norm_stage.sv
// tb/tb_fp32_norm_stage.sv - self-checking bench for fp32_norm_stage
module tb_fp32_norm_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [31:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [31:0] out_mant;
  logic [5:0]  out_lzc;
  logic        out_zero;
  logic        out_denorm;
  logic [50:0] dut_out;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          lat_chk = 0;
  logic [50:0] exp_q [$];
  int          acc_q [$];

  fp32_norm_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_mant   (out_mant),
    .out_lzc    (out_lzc),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  assign dut_out = {out_sign, out_exp, out_mant, out_lzc, out_zero, out_denorm};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: normalise by plain integer arithmetic.
  function automatic logic [50:0] model(input logic s, input logic [9:0] e, input logic [31:0] m);
    int          lz, ei, sh, oe;
    logic [31:0] om;
    logic        z, dn;
    ei = int'($signed(e));
    lz = 0;
    while (lz < 32 && !m[31-lz]) lz++;
    z = 1'b0; dn = 1'b0;
    if (m == 0) begin
      om = 0; oe = 0; z = 1'b1;
    end else if (ei - lz >= 1) begin
      om = m << lz; oe = ei - lz;
    end else begin
      sh = (ei - 1 > 0) ? ei - 1 : 0;
      om = m << sh; oe = 0; dn = 1'b1;
    end
    return {s, 10'(oe), om, 6'(lz), z, dn};
  endfunction

  // One clock: settle, score the handshakes of this cycle, advance.
  task automatic tick(output bit acc);
    logic [50:0] e;
    int          a;
    #1;
    acc = 0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("data", 64'(dut_out), 64'(e));
          if (lat_chk) chk("latency", 64'(cyc - a), 64'd2);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1;
        exp_q.push_back(model(in_sign, in_exp, in_mant));
        acc_q.push_back(cyc);
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end
    #1;
  endtask

  task automatic drive_rand();
    in_sign = 1'($urandom);
    in_exp  = 10'($urandom_range(0, 511)) - 10'd64;
    in_mant = 32'($urandom) >> $urandom_range(0, 32);
  endtask

  task automatic drain();
    bit a;
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(a);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic direct(input string tag, input logic s, input logic [9:0] e,
                        input logic [31:0] m, input logic [50:0] want);
    bit a;
    out_ready = 1;
    in_valid = 1; in_sign = s; in_exp = e; in_mant = m;
    tick(a);
    in_valid = 0;
    tick(a);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(dut_out), 64'(want));
    tick(a);
  endtask

  initial begin
    bit          a;
    int          idx;
    logic [50:0] snap;
    logic [31:0] bp_m [4];
    logic [9:0]  bp_e [4];

    rst_n = 0; in_valid = 0; in_sign = 0; in_exp = '0; in_mant = '0; out_ready = 0;
    tick(a); tick(a);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(dut_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1;
    tick(a);

    direct("norm_16", 1'b1, 10'd150, 32'h0000_8000, {1'b1, 10'd134, 32'h8000_0000, 6'd16, 1'b0, 1'b0});
    direct("uf_exp5", 1'b0, 10'd5, 32'h0000_0001, {1'b0, 10'd0, 32'h0000_0010, 6'd31, 1'b0, 1'b1});
    direct("uf_negexp", 1'b0, 10'(-3), 32'h0000_0001, {1'b0, 10'd0, 32'h0000_0001, 6'd31, 1'b0, 1'b1});
    direct("zero", 1'b0, 10'd100, 32'h0, {1'b0, 10'd0, 32'h0, 6'd32, 1'b1, 1'b0});
    direct("pass_lz0", 1'b0, 10'd1, 32'h8000_0000, {1'b0, 10'd1, 32'h8000_0000, 6'd0, 1'b0, 1'b0});

    // Backpressure: 4 offered, only 2 fit, outputs frozen, all drain in order.
    for (int i = 0; i < 4; i++) begin
      bp_m[i] = 32'($urandom) >> (4 * i + 1);
      bp_e[i] = 10'($urandom_range(1, 300));
    end
    out_ready = 0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1; in_sign = 1'(idx); in_exp = bp_e[idx]; in_mant = bp_m[idx];
      tick(a);
      if (a) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    snap = dut_out;
    for (int c = 0; c < 5; c++) begin
      tick(a);
      chk("bp_hold_vld", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(dut_out), 64'(snap));
    end
    out_ready = 1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_valid = 1; in_sign = 1'(idx); in_exp = bp_e[idx]; in_mant = bp_m[idx];
      tick(a);
      if (a) idx++;
    end
    chk("bp_all_in", 64'(idx), 64'd4);
    drain();

    // Streaming at full rate with exact latency.
    lat_chk = 1;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      drive_rand();
      chk("stream_rdy", 64'(in_ready), 64'd1);
      if (i >= 2) chk("stream_out_vld", 64'(out_valid), 64'd1);
      tick(a);
    end
    drain();
    lat_chk = 0;

    // Random valid/ready toggling; source holds data while stalled.
    in_valid = 0; a = 1;
    for (int i = 0; i < 300; i++) begin
      if (a || !in_valid) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        drive_rand();
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick(a);
    end
    drain();

    // Reset with both stages full: nothing must survive.
    out_ready = 0; idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      in_valid = 1; drive_rand();
      tick(a);
      if (a) idx++;
    end
    in_valid = 0;
    chk("rst_mid_full", 64'(in_ready), 64'd0);
    rst_n = 0;
    tick(a);
    rst_n = 1;
    chk("rst_mid_vld", 64'(out_valid), 64'd0);
    chk("rst_mid_data", 64'(dut_out), 64'd0);
    chk("rst_mid_rdy", 64'(in_ready), 64'd1);
    out_ready = 1;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) idx++;
      tick(a);
    end
    chk("rst_no_stale", 64'(idx), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
